mem_stage: RTL and testbench

Memory-access stage of the five-stage in-order pipeline, between the execute stage and the write-back stage. It registers the execute-stage bus, waits for the data-SRAM response of a load, aligns and extends the returned word, and hands {pc, gr_we, dest, final_result} to write-back over a valid/allow-in handshake. It also publishes a forwarding bus with a load-pending flag so decode can stall on load-use hazards.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage in-order pipeline.
// Registers the execute-stage bus, waits for the data-SRAM load response,
// aligns/extends the returned word and hands the result to write-back over a
// valid/allow-in handshake. Publishes a forwarding bus with a load-pending flag.
// Optional feature macro: MS_SUBWORD_LOAD_EN (byte/halfword load alignment and
// extension). When undefined, every load returns the raw 32-bit word.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_ms_bus,
    output logic        ms_allow_in,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allow_in,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_ws_bus,
    output logic [38:0] ms_fwd_bus
);

    // Load op encodings carried in mem_op
    localparam logic [2:0] OP_LD_B  = 3'b001;
    localparam logic [2:0] OP_LD_BU = 3'b101;
    localparam logic [2:0] OP_LD_H  = 3'b010;
    localparam logic [2:0] OP_LD_HU = 3'b110;

    logic        ms_valid_reg;
    logic        ms_valid_next;
    logic [73:0] es_ms_bus_reg;
    logic [73:0] es_ms_bus_next;
    logic        data_buf_valid_reg;
    logic        data_buf_valid_next;
    logic [31:0] data_buf_reg;
    logic [31:0] data_buf_next;

    // Fields of the latched execute-stage bus
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  mem_op;
    logic [1:0]  ld_addr;

    assign pc           = es_ms_bus_reg[73:42];
    assign gr_we        = es_ms_bus_reg[41];
    assign dest         = es_ms_bus_reg[40:36];
    assign alu_result   = es_ms_bus_reg[35:4];
    assign res_from_mem = es_ms_bus_reg[3];
    assign mem_op       = es_ms_bus_reg[2:0];
    assign ld_addr      = alu_result[1:0];

    logic        ms_ready_go;
    logic        load_pending;
    logic [31:0] raw_word;
    logic [31:0] load_result;
    logic [31:0] final_result;

    // A load is ready once its data arrives this cycle or was buffered earlier
    assign ms_ready_go    = !res_from_mem || data_sram_data_ok || data_buf_valid_reg;
    assign ms_allow_in    = !ms_valid_reg || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign load_pending   = ms_valid_reg && res_from_mem && !ms_ready_go;

    // Buffered data takes priority; a live data_ok is then a protocol violation
    assign raw_word = data_buf_valid_reg ? data_buf_reg : data_sram_rdata;

`ifdef MS_SUBWORD_LOAD_EN
    logic [7:0] raw_bytes [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign raw_bytes[gi] = raw_word[gi*8 +: 8];
        end
    endgenerate

    // Halfword selection ignores addr[0]; misalignment is not trapped here
    assign sel_byte = raw_bytes[ld_addr];
    assign sel_half = ld_addr[1] ? raw_word[31:16] : raw_word[15:0];

    // Sign/zero extension by load type; unknown codes behave as ld.w
    always_comb begin
        load_result = raw_word;
        case (mem_op)
            OP_LD_B:  load_result = {{24{sel_byte[7]}}, sel_byte};
            OP_LD_BU: load_result = {24'h000000, sel_byte};
            OP_LD_H:  load_result = {{16{sel_half[15]}}, sel_half};
            OP_LD_HU: load_result = {16'h0000, sel_half};
            default:  load_result = raw_word;
        endcase
    end
`else
    // Without sub-word support the op code and low address bits do not steer data
    logic unused_sel;
    assign unused_sel  = ^{mem_op, ld_addr, OP_LD_B, OP_LD_BU, OP_LD_H, OP_LD_HU};
    assign load_result = raw_word;
`endif

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ms_ws_bus  = {pc, gr_we, dest, final_result};
    assign ms_fwd_bus = {ms_valid_reg & gr_we, dest, final_result, load_pending};

    // Next-state: accept a new instruction, or buffer load data while write-back stalls
    always_comb begin
        ms_valid_next       = ms_valid_reg;
        es_ms_bus_next      = es_ms_bus_reg;
        data_buf_valid_next = data_buf_valid_reg;
        data_buf_next       = data_buf_reg;
        if (ms_allow_in) begin
            ms_valid_next       = es_to_ms_valid;
            data_buf_valid_next = 1'b0;
            if (es_to_ms_valid) begin
                es_ms_bus_next = es_ms_bus;
            end
        end else if (data_sram_data_ok && ms_valid_reg && res_from_mem
                     && !data_buf_valid_reg) begin
            // Stage is held only because write-back is not accepting
            data_buf_valid_next = 1'b1;
            data_buf_next       = data_sram_rdata;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_reg       <= 1'b0;
            data_buf_valid_reg <= 1'b0;
        end else begin
            ms_valid_reg       <= ms_valid_next;
            data_buf_valid_reg <= data_buf_valid_next;
        end
    end

    // Data registers carry no reset; they are qualified by the valid flags
    always_ff @(posedge clk) begin
        es_ms_bus_reg <= es_ms_bus_next;
        data_buf_reg  <= data_buf_next;
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Expected load results depend on MS_SUBWORD_LOAD_EN, selected at compile time.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic [73:0] es_ms_bus;
    logic        ms_allow_in;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [69:0] ms_ws_bus;
    logic [38:0] ms_fwd_bus;

    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_ms_bus         (es_ms_bus),
        .ms_allow_in       (ms_allow_in),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_ws_bus         (ms_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk_bus(input logic [31:0] pc, input logic we,
                                           input logic [4:0] dest, input logic [31:0] alu,
                                           input logic rfm, input logic [2:0] op);
        return {pc, we, dest, alu, rfm, op};
    endfunction

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ms_to_ws_valid); end
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL reset_allow_in got=%0h exp=1", ms_allow_in); end
        total++; if (ms_fwd_bus[38] !== 1'b0) begin bad++; $display("FAIL reset_fwd_we got=%0h exp=0", ms_fwd_bus[38]); end
        total++; if (ms_fwd_bus[0] !== 1'b0) begin bad++; $display("FAIL reset_load_pending got=%0h exp=0", ms_fwd_bus[0]); end
        $display("reset: valid=%0h allow_in=%0h", ms_to_ws_valid, ms_allow_in);
    endtask

    task automatic test_non_load();
        next_cycle();
        ws_allow_in    = 1'b1;
        es_to_ms_valid = 1'b1;
        es_ms_bus      = mk_bus(32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, 3'b000);
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL nonload_valid got=%0h exp=1", ms_to_ws_valid); end
        total++; if (ms_ws_bus !== {32'h1c000000, 1'b1, 5'd5, 32'h12345678}) begin bad++; $display("FAIL nonload_bus got=%h exp=%h", ms_ws_bus, {32'h1c000000, 1'b1, 5'd5, 32'h12345678}); end
        total++; if (ms_fwd_bus !== {1'b1, 5'd5, 32'h12345678, 1'b0}) begin bad++; $display("FAIL nonload_fwd got=%h exp=%h", ms_fwd_bus, {1'b1, 5'd5, 32'h12345678, 1'b0}); end
        next_cycle();
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL nonload_leave got=%0h exp=0", ms_to_ws_valid); end
        $display("non_load: bus=%h", {32'h1c000000, 1'b1, 5'd5, 32'h12345678});
    endtask

    // Load with data_ok two cycles after acceptance
    task automatic test_load(input string name, input logic [2:0] op, input logic [1:0] addr,
                             input logic [31:0] rd, input logic [31:0] exp_sub,
                             input logic [31:0] exp_raw);
        logic [31:0] exp;
`ifdef MS_SUBWORD_LOAD_EN
        exp = exp_sub;
`else
        exp = exp_raw;
`endif
        next_cycle();
        ws_allow_in       = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        es_to_ms_valid    = 1'b1;
        es_ms_bus         = mk_bus(32'h1c000100, 1'b1, 5'd7, {30'h00000400, addr}, 1'b1, op);
        #1;
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL %s_allow_in got=%0h exp=1", name, ms_allow_in); end
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL %s_pending1 got=%0h exp=1", name, ms_fwd_bus[0]); end
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_wait_valid got=%0h exp=0", name, ms_to_ws_valid); end
        next_cycle();
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL %s_pending2 got=%0h exp=1", name, ms_fwd_bus[0]); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%0h exp=1", name, ms_to_ws_valid); end
        total++; if (ms_ws_bus[31:0] !== exp) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, ms_ws_bus[31:0], exp); end
        total++; if (ms_fwd_bus !== {1'b1, 5'd7, exp, 1'b0}) begin bad++; $display("FAIL %s_fwd got=%h exp=%h", name, ms_fwd_bus, {1'b1, 5'd7, exp, 1'b0}); end
        total++; if (ms_ws_bus[69:38] !== 32'h1c000100) begin bad++; $display("FAIL %s_pc got=%h exp=1c000100", name, ms_ws_bus[69:38]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL %s_leave got=%0h exp=0", name, ms_to_ws_valid); end
        $display("load %s: op=%b addr=%b rdata=%h exp=%h", name, op, addr, rd, exp);
    endtask

    task automatic test_buffering();
        logic [31:0] exp;
`ifdef MS_SUBWORD_LOAD_EN
        exp = 32'h0000BEEF;
`else
        exp = 32'hBEEF1234;
`endif
        next_cycle();
        ws_allow_in    = 1'b0;
        es_to_ms_valid = 1'b1;
        es_ms_bus      = mk_bus(32'h1c000300, 1'b1, 5'd9, 32'h00002002, 1'b1, 3'b110);
        next_cycle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF1234;
        #1;
        total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL buf_ok_valid got=%0h exp=1", ms_to_ws_valid); end
        total++; if (ms_allow_in !== 1'b0) begin bad++; $display("FAIL buf_ok_allow_in got=%0h exp=0", ms_allow_in); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            // middle hold cycle carries a stray data_ok that must be ignored
            data_sram_data_ok = (i == 1);
            data_sram_rdata   = 32'hDEAD0000 + i;
            #1;
            total++; if (ms_ws_bus[31:0] !== exp) begin bad++; $display("FAIL buf_hold%0d_result got=%h exp=%h", i, ms_ws_bus[31:0], exp); end
            total++; if (ms_allow_in !== 1'b0) begin bad++; $display("FAIL buf_hold%0d_allow_in got=%0h exp=0", i, ms_allow_in); end
            total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL buf_hold%0d_valid got=%0h exp=1", i, ms_to_ws_valid); end
        end
        next_cycle();
        data_sram_data_ok = 1'b0;
        ws_allow_in       = 1'b1;
        es_to_ms_valid    = 1'b1;
        es_ms_bus         = mk_bus(32'h1c000400, 1'b1, 5'd10, 32'h00003000, 1'b1, 3'b000);
        #1;
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL buf_release_allow_in got=%0h exp=1", ms_allow_in); end
        total++; if (ms_ws_bus !== {32'h1c000300, 1'b1, 5'd9, exp}) begin bad++; $display("FAIL buf_release_bus got=%h exp=%h", ms_ws_bus, {32'h1c000300, 1'b1, 5'd9, exp}); end
        next_cycle();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h33333333;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL buf_cleared_valid got=%0h exp=0", ms_to_ws_valid); end
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL buf_cleared_pending got=%0h exp=1", ms_fwd_bus[0]); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        #1;
        total++; if (ms_ws_bus !== {32'h1c000400, 1'b1, 5'd10, 32'hCAFEF00D}) begin bad++; $display("FAIL buf_next_bus got=%h exp=%h", ms_ws_bus, {32'h1c000400, 1'b1, 5'd10, 32'hCAFEF00D}); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL buf_next_leave got=%0h exp=0", ms_to_ws_valid); end
        $display("buffering: held=%h", exp);
    endtask

    task automatic test_reset_mid_load();
        next_cycle();
        ws_allow_in    = 1'b1;
        es_to_ms_valid = 1'b1;
        es_ms_bus      = mk_bus(32'h1c000500, 1'b1, 5'd11, 32'h00004000, 1'b1, 3'b000);
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_pending got=%0h exp=1", ms_fwd_bus[0]); end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0h exp=0", ms_to_ws_valid); end
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL rst_mid_allow_in got=%0h exp=1", ms_allow_in); end
        total++; if (ms_fwd_bus[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_pending_clr got=%0h exp=0", ms_fwd_bus[0]); end
        total++; if (ms_fwd_bus[38] !== 1'b0) begin bad++; $display("FAIL rst_mid_fwd_we got=%0h exp=0", ms_fwd_bus[38]); end
        $display("reset_mid_load: valid=%0h allow_in=%0h", ms_to_ws_valid, ms_allow_in);
    endtask

    task automatic test_stray_data_ok();
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00000055;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL stray_valid got=%0h exp=0", ms_to_ws_valid); end
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL stray_allow_in got=%0h exp=1", ms_allow_in); end
        total++; if (ms_fwd_bus[38] !== 1'b0) begin bad++; $display("FAIL stray_fwd_we got=%0h exp=0", ms_fwd_bus[38]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        es_to_ms_valid    = 1'b1;
        es_ms_bus         = mk_bus(32'h1c000600, 1'b1, 5'd12, 32'h00005000, 1'b1, 3'b000);
        next_cycle();
        es_to_ms_valid = 1'b0;
        #1;
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL stray_load_valid got=%0h exp=0", ms_to_ws_valid); end
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL stray_load_pending got=%0h exp=1", ms_fwd_bus[0]); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h13579BDF;
        #1;
        total++; if (ms_ws_bus[31:0] !== 32'h13579BDF) begin bad++; $display("FAIL stray_load_result got=%h exp=13579bdf", ms_ws_bus[31:0]); end
        next_cycle();
        data_sram_data_ok = 1'b0;
        $display("stray_data_ok: load result=%h", 32'h13579BDF);
    endtask

    task automatic test_back_to_back();
        next_cycle();
        ws_allow_in    = 1'b1;
        es_to_ms_valid = 1'b1;
        es_ms_bus      = mk_bus(32'h1c001000, 1'b1, 5'd1, 32'hA0A0A0A1, 1'b0, 3'b000);
        next_cycle();
        es_ms_bus = mk_bus(32'h1c001004, 1'b1, 5'd2, 32'hB0B0B0B2, 1'b0, 3'b000);
        #1;
        total++; if (ms_ws_bus !== {32'h1c001000, 1'b1, 5'd1, 32'hA0A0A0A1}) begin bad++; $display("FAIL b2b_a_bus got=%h exp=%h", ms_ws_bus, {32'h1c001000, 1'b1, 5'd1, 32'hA0A0A0A1}); end
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL b2b_a_allow_in got=%0h exp=1", ms_allow_in); end
        next_cycle();
        es_ms_bus = mk_bus(32'h1c001008, 1'b1, 5'd3, 32'h00006000, 1'b1, 3'b000);
        #1;
        total++; if (ms_ws_bus !== {32'h1c001004, 1'b1, 5'd2, 32'hB0B0B0B2}) begin bad++; $display("FAIL b2b_b_bus got=%h exp=%h", ms_ws_bus, {32'h1c001004, 1'b1, 5'd2, 32'hB0B0B0B2}); end
        total++; if (ms_to_ws_valid !== 1'b1) begin bad++; $display("FAIL b2b_b_valid got=%0h exp=1", ms_to_ws_valid); end
        next_cycle();
        es_ms_bus = mk_bus(32'h1c00100c, 1'b0, 5'd4, 32'hC0C0C0C4, 1'b0, 3'b000);
        #1;
        total++; if (ms_allow_in !== 1'b0) begin bad++; $display("FAIL b2b_load_allow_in got=%0h exp=0", ms_allow_in); end
        total++; if (ms_fwd_bus[0] !== 1'b1) begin bad++; $display("FAIL b2b_load_pending got=%0h exp=1", ms_fwd_bus[0]); end
        next_cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h77777777;
        #1;
        total++; if (ms_allow_in !== 1'b1) begin bad++; $display("FAIL b2b_load_done_allow_in got=%0h exp=1", ms_allow_in); end
        total++; if (ms_ws_bus !== {32'h1c001008, 1'b1, 5'd3, 32'h77777777}) begin bad++; $display("FAIL b2b_load_bus got=%h exp=%h", ms_ws_bus, {32'h1c001008, 1'b1, 5'd3, 32'h77777777}); end
        next_cycle();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        total++; if (ms_ws_bus !== {32'h1c00100c, 1'b0, 5'd4, 32'hC0C0C0C4}) begin bad++; $display("FAIL b2b_c_bus got=%h exp=%h", ms_ws_bus, {32'h1c00100c, 1'b0, 5'd4, 32'hC0C0C0C4}); end
        total++; if (ms_fwd_bus[38] !== 1'b0) begin bad++; $display("FAIL b2b_c_fwd_we got=%0h exp=0", ms_fwd_bus[38]); end
        next_cycle();
        total++; if (ms_to_ws_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h exp=0", ms_to_ws_valid); end
        $display("back_to_back: three non-loads around one load");
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_ms_bus         = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_allow_in       = 1'b1;

        test_reset();
        test_non_load();
        test_load("ldb",     3'b001, 2'b11, 32'h80AABBCC, 32'hFFFFFF80, 32'h80AABBCC);
        test_load("ldbu",    3'b101, 2'b11, 32'h80AABBCC, 32'h00000080, 32'h80AABBCC);
        test_load("ldb0",    3'b001, 2'b00, 32'h80AABBCC, 32'hFFFFFFCC, 32'h80AABBCC);
        test_load("ldbu1",   3'b101, 2'b01, 32'h80AABBCC, 32'h000000BB, 32'h80AABBCC);
        test_load("ldhu",    3'b110, 2'b10, 32'hBEEF1234, 32'h0000BEEF, 32'hBEEF1234);
        test_load("ldh",     3'b010, 2'b10, 32'hBEEF1234, 32'hFFFFBEEF, 32'hBEEF1234);
        test_load("ldh_odd", 3'b010, 2'b11, 32'hBEEF1234, 32'hFFFFBEEF, 32'hBEEF1234);
        test_load("ldh_lo",  3'b010, 2'b01, 32'hBEEF9234, 32'hFFFF9234, 32'hBEEF9234);
        test_load("ldw",     3'b000, 2'b11, 32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC);
        test_load("ldrsv",   3'b111, 2'b11, 32'h80AABBCC, 32'h80AABBCC, 32'h80AABBCC);
        test_buffering();
        test_reset_mid_load();
        test_stray_data_ok();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
